// File: rtl/conv_pool_stage_if.sv
// conv_pool_stage_if: input word stream and pooled output stream of conv_pool_stage.
interface conv_pool_stage_if #(parameter int width = 32);
  logic             frame_start;
  logic             relu_en;
  logic [width-1:0] result;
  logic             result_en;
  logic [width-1:0] pool_out;
  logic             pool_en;
  logic             frame_end;
  logic             busy;
  modport master (output frame_start, relu_en, result, result_en,
                  input  pool_out, pool_en, frame_end, busy);
  modport slave  (input  frame_start, relu_en, result, result_en,
                  output pool_out, pool_en, frame_end, busy);
endinterface

// File: rtl/conv_pool_stage.sv
// conv_pool_stage: streaming ReLU plus 2x2/stride-2 signed max-pool over a raster map.
module conv_pool_stage #(
  parameter int width    = 32,
  parameter int map_size = 62,
  parameter int col_bits = 6
) (
  input logic             clk,
  input logic             rst_n,
  conv_pool_stage_if.slave bus
);
  localparam int lb_n = map_size / 2;
  localparam int ib   = (lb_n > 1) ? $clog2(lb_n) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                  r_state, w_next;
  logic [col_bits-1:0]     r_col, r_row;
  logic signed [width-1:0] r_pair, r_pool_out, w_v, w_h, w_p, w_lb;
  logic signed [width-1:0] r_linebuf [lb_n];
  logic [ib-1:0]           w_idx;
  logic                    r_pool_en, r_frame_end, w_acc, w_last_col, w_last, w_emit;
  // frame_start wins over a coincident word, so that word is dropped
  assign w_acc      = r_state == RUN && bus.result_en && !bus.frame_start;
  assign w_last_col = r_col == col_bits'(map_size - 1);
  assign w_last     = w_acc && w_last_col && r_row == col_bits'(map_size - 1);
  assign w_emit     = w_acc && r_row[0] && r_col[0];
  assign w_idx      = ib'(r_col >> 1);
  assign w_v        = (bus.relu_en && bus.result[width-1]) ? '0 : bus.result;
  assign w_h        = r_pair > w_v ? r_pair : w_v;
  assign w_lb       = r_linebuf[w_idx];
  assign w_p        = w_lb > w_h ? w_lb : w_h;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb w_next = bus.frame_start ? RUN : (w_last ? IDLE : r_state);
  always_comb begin
    bus.busy      = r_state == RUN;
    bus.pool_out  = r_pool_out;
    bus.pool_en   = r_pool_en;
    bus.frame_end = r_frame_end;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_pair      <= '0;
      r_pool_out  <= '0;
      r_pool_en   <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_pool_en   <= w_emit;
      r_frame_end <= w_last;
      if (w_emit) r_pool_out <= w_p;
      if (bus.frame_start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_pair <= '0;
      end else if (w_acc) begin
        r_col <= w_last_col ? '0 : r_col + 1'b1;
        if (w_last_col) r_row <= r_row == col_bits'(map_size - 1) ? '0 : r_row + 1'b1;
        if (!r_col[0]) r_pair <= w_v;
      end
    end
  // even rows park the horizontal max; odd rows only read, so no same-cycle conflict
  always_ff @(posedge clk)
    if (w_acc && !r_row[0] && r_col[0]) r_linebuf[w_idx] <= w_h;
endmodule

// File: tb/tb_conv_pool_stage.sv
// tb_conv_pool_stage: table vectors, random frames vs a 2-D max-pool model, and restart/reset/re-arm sequences.
module tb_conv_pool_stage;
  localparam int W = 32, M = 4;
  typedef struct packed {
    logic [15:0][31:0] d;
    logic              relu;
    logic [3:0][31:0]  e;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  conv_pool_stage_if #(.width(W)) bus();
  conv_pool_stage #(.width(W), .map_size(M), .col_bits(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int pass_n = 0, tot = 0, cyc = 0, fe_n = 0;
  logic [31:0] got_v [$];
  bit          got_fe [$];
  int          got_c [$];
  int          exp_c [$];
  vec_t        tbl [4];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.pool_en) begin
      got_v.push_back(bus.pool_out);
      got_fe.push_back(bus.frame_end);
      got_c.push_back(cyc);
    end
    if (bus.frame_end) fe_n++;
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tot++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask
  task automatic clear_q();
    got_v.delete(); got_fe.delete(); got_c.delete(); exp_c.delete(); fe_n = 0;
  endtask
  task automatic pulse_start();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask
  task automatic drive_word(logic [31:0] x, bit relu, int gap, bit mark);
    bus.result = x; bus.relu_en = relu; bus.result_en = 1'b1;
    if (mark) exp_c.push_back(cyc + 1);
    @(posedge clk); #1;
    bus.result_en = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task automatic drive_frame(logic [15:0][31:0] d, bit relu, int maxgap, bit start);
    if (start) pulse_start();
    for (int i = 0; i < 16; i++)
      drive_word(d[i], relu, (i == 15 || maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)),
                 (i / 4) % 2 == 1 && i % 2 == 1);
  endtask
  function automatic logic signed [31:0] relu_f(logic [31:0] x, bit relu);
    return (relu && x[31]) ? 32'sd0 : $signed(x);
  endfunction
  // pooled map straight from the definition: max of each 2x2 block
  function automatic logic [3:0][31:0] model(logic [15:0][31:0] d, bit relu);
    logic [3:0][31:0] o;
    for (int b = 0; b < 4; b++) begin
      logic signed [31:0] m;
      m = relu_f(d[(b / 2) * 8 + (b % 2) * 2], relu);
      for (int k = 1; k < 4; k++) begin
        logic signed [31:0] x;
        x = relu_f(d[((b / 2) * 2 + k / 2) * 4 + (b % 2) * 2 + k % 2], relu);
        if (x > m) m = x;
      end
      o[b] = m;
    end
    return o;
  endfunction
  task automatic check_frame(string name, logic [3:0][31:0] e);
    repeat (4) begin @(posedge clk); #1; end
    chk({name, " count"}, got_v.size(), 4);
    for (int i = 0; i < 4 && i < got_v.size(); i++) begin
      chk($sformatf("%s out%0d", name, i), got_v[i], e[i]);
      chk($sformatf("%s frame_end%0d", name, i), 32'(got_fe[i]), 32'(i == 3));
      if (i < exp_c.size()) chk($sformatf("%s latency%0d", name, i), got_c[i], exp_c[i]);
    end
    clear_q();
  endtask
  initial begin
    logic [15:0][31:0] rd;
    bit rr;
    bus.frame_start = 1'b0; bus.relu_en = 1'b1; bus.result = '0; bus.result_en = 1'b0;
    for (int i = 0; i < 16; i++) tbl[0].d[i] = 32'(i + 1);
    tbl[0].relu = 1'b1;
    tbl[0].e = {32'd16, 32'd14, 32'd8, 32'd6};
    for (int i = 0; i < 16; i++) tbl[1].d[i] = 32'hFFFF_FFFB;
    tbl[1].d[4] = 32'd3;
    tbl[1].relu = 1'b1;
    tbl[1].e = {32'd0, 32'd0, 32'd0, 32'd3};
    tbl[2] = tbl[1];
    tbl[2].relu = 1'b0;
    tbl[2].e = {32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd3};
    tbl[3].d = '0;
    tbl[3].d[0] = 32'h7FFF_FFFF; tbl[3].d[1] = 32'h8000_0000;
    tbl[3].d[4] = 32'hFFFF_FFFF; tbl[3].d[5] = 32'h0;
    tbl[3].relu = 1'b0;
    tbl[3].e = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset pool_out", bus.pool_out, 0);
    chk("reset pool_en", 32'(bus.pool_en), 0);
    chk("reset frame_end", 32'(bus.frame_end), 0);
    chk("reset busy", 32'(bus.busy), 0);
    clear_q();
    for (int t = 0; t < 4; t++) begin
      drive_frame(tbl[t].d, tbl[t].relu, 0, 1'b1);
      check_frame($sformatf("vec%0d", t), tbl[t].e);
      chk($sformatf("vec%0d busy after", t), 32'(bus.busy), 0);
    end
    pulse_start();
    chk("busy in run", 32'(bus.busy), 1);
    drive_frame(tbl[0].d, 1'b1, 3, 1'b0);
    check_frame("sparse", tbl[0].e);
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) rd[i] = (f % 2 == 0) ? $urandom : 32'($signed($urandom_range(20, 0)) - 10);
      rr = 1'($urandom_range(1, 0));
      drive_frame(rd, rr, 2, 1'b1);
      check_frame($sformatf("rand%0d", f), model(rd, rr));
    end
    pulse_start();
    for (int i = 0; i < 7; i++) drive_word(32'(100 + i), 1'b1, 0, 1'b0);
    clear_q();
    drive_frame(tbl[0].d, 1'b1, 0, 1'b1);
    check_frame("restart", tbl[0].e);
    pulse_start();
    for (int i = 0; i < 6; i++) drive_word(32'(50 + i), 1'b1, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midreset pool_out", bus.pool_out, 0);
    chk("midreset pool_en", 32'(bus.pool_en), 0);
    chk("midreset busy", 32'(bus.busy), 0);
    chk("midreset frame_end", 32'(bus.frame_end), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 16; i++) drive_word(32'(i + 1), 1'b1, 0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("idle guard outputs", got_v.size(), 0);
    clear_q();
    drive_frame(tbl[0].d, 1'b1, 0, 1'b1);
    drive_frame(tbl[2].d, 1'b0, 0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    chk("rearm count", got_v.size(), 8);
    chk("rearm frame_end pulses", fe_n, 2);
    for (int i = 0; i < 8 && i < got_v.size(); i++)
      chk($sformatf("rearm out%0d", i), got_v[i], i < 4 ? tbl[0].e[i] : tbl[2].e[i - 4]);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
